// File: rtl/mips_cpu_alu_core.sv
// rtl/mips_cpu_alu_core.sv - MIPS-I integer ALU with registered HI/LO multiply/divide unit
//
// Purpose: combinational 32-bit ALU (result, branch condition) plus the
// architectural HI/LO registers written on the write strobe.
// Optional feature macro: MIPS_ALU_DIV_EN (enables DIV/DIVU; otherwise they are no-ops).
//
// Ports:
//   clk        in   1   clock; HI/LO update on rising edge
//   reset      in   1   synchronous, active-high; clears HI/LO, overrides write
//   alu_func   in   5   ALU function select
//   mult_op    in   3   HI/LO operation select
//   a, b       in  32   operands
//   shift      in   5   shift amount (shamt)
//   write      in   1   HI/LO write strobe
//   hi, lo     out 32   current HI/LO
//   condition  out  1   branch-taken flag
//   result     out 32   ALU result

module mips_cpu_alu_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  alu_func,
    input  logic [2:0]  mult_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shift,
    input  logic        write,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        condition,
    output logic [31:0] result
);

    localparam logic [4:0] F_ADD  = 5'd0,  F_SUB  = 5'd1,  F_AND  = 5'd2,  F_OR   = 5'd3;
    localparam logic [4:0] F_XOR  = 5'd4,  F_NOR  = 5'd5,  F_SLT  = 5'd6,  F_SLTU = 5'd7;
    localparam logic [4:0] F_SLL  = 5'd8,  F_SRL  = 5'd9,  F_SRA  = 5'd10, F_SLLV = 5'd11;
    localparam logic [4:0] F_SRLV = 5'd12, F_SRAV = 5'd13, F_LUI  = 5'd14, F_MFHI = 5'd15;
    localparam logic [4:0] F_MFLO = 5'd16, F_PASS = 5'd17, F_BEQ  = 5'd18, F_BNE  = 5'd19;
    localparam logic [4:0] F_BLEZ = 5'd20, F_BGTZ = 5'd21, F_BLTZ = 5'd22, F_BGEZ = 5'd23;

    localparam logic [2:0] M_MULT = 3'd1, M_MULTU = 3'd2, M_DIV = 3'd3, M_DIVU = 3'd4;
    localparam logic [2:0] M_MTHI = 3'd5, M_MTLO  = 3'd6;

    logic [31:0] diff;
    logic [4:0]  var_amt;
    logic        a_is_zero;

    assign diff      = a - b;
    assign var_amt   = a[4:0];
    assign a_is_zero = (a == 32'd0);

    always_comb begin
        result    = 32'd0;
        condition = 1'b0;
        case (alu_func)
            F_ADD:  result = a + b;
            F_SUB:  result = diff;
            F_AND:  result = a & b;
            F_OR:   result = a | b;
            F_XOR:  result = a ^ b;
            F_NOR:  result = ~(a | b);
            F_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            F_SLTU: result = {31'd0, a < b};
            F_SLL:  result = b << shift;
            F_SRL:  result = b >> shift;
            F_SRA:  result = $unsigned($signed(b) >>> shift);
            F_SLLV: result = b << var_amt;
            F_SRLV: result = b >> var_amt;
            F_SRAV: result = $unsigned($signed(b) >>> var_amt);
            F_LUI:  result = {b[15:0], 16'h0000};
            F_MFHI: result = hi;
            F_MFLO: result = lo;
            F_PASS: result = a;
            F_BEQ:  begin result = diff; condition = (a == b);             end
            F_BNE:  begin result = diff; condition = (a != b);             end
            F_BLEZ: begin result = diff; condition = a[31] | a_is_zero;    end
            F_BGTZ: begin result = diff; condition = ~a[31] & ~a_is_zero;  end
            F_BLTZ: begin result = diff; condition = a[31];                end
            F_BGEZ: begin result = diff; condition = ~a[31];               end
            default: ;
        endcase
    end

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MIPS_ALU_DIV_EN
    // Signed divide is done on magnitudes so truncation toward zero and the
    // remainder-follows-dividend rule fall out directly; 0x80000000 / -1
    // yields magnitude 0x80000000 which re-negates to itself, remainder 0.
    // The zero divisor is replaced by 1 only to keep the dividers defined;
    // the register update is suppressed for b == 0 anyway.
    logic [31:0] div_b, mag_a, mag_b, mag_q, mag_r;
    logic [31:0] udiv_q, udiv_r, sdiv_q, sdiv_r;

    assign div_b  = (b == 32'd0) ? 32'd1 : b;
    assign udiv_q = a / div_b;
    assign udiv_r = a % div_b;
    assign mag_a  = a[31] ? -a : a;
    assign mag_b  = b[31] ? -b : div_b;
    assign mag_q  = mag_a / mag_b;
    assign mag_r  = mag_a % mag_b;
    assign sdiv_q = (a[31] ^ b[31]) ? -mag_q : mag_q;
    assign sdiv_r = a[31] ? -mag_r : mag_r;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (write) begin
            case (mult_op)
                M_MULT:  {hi, lo} <= prod_s;
                M_MULTU: {hi, lo} <= prod_u;
`ifdef MIPS_ALU_DIV_EN
                M_DIV: if (b != 32'd0) begin
                    lo <= sdiv_q;
                    hi <= sdiv_r;
                end
                M_DIVU: if (b != 32'd0) begin
                    lo <= udiv_q;
                    hi <= udiv_r;
                end
`endif
                M_MTHI:  hi <= a;
                M_MTLO:  lo <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_alu_core.sv
// tb/tb_mips_cpu_alu_core.sv - randomized self-checking bench for mips_cpu_alu_core

module tb_mips_cpu_alu_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  alu_func;
    logic [2:0]  mult_op;
    logic [31:0] a, b;
    logic [4:0]  shift;
    logic        write;
    logic [31:0] hi, lo, result;
    logic        condition;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mh, ml;

    mips_cpu_alu_core dut (
        .clk(clk), .reset(reset), .alu_func(alu_func), .mult_op(mult_op),
        .a(a), .b(b), .shift(shift), .write(write),
        .hi(hi), .lo(lo), .condition(condition), .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [32:0] model_alu(input logic [4:0] f, input logic [31:0] av, input logic [31:0] bv,
                                             input logic [4:0] sh, input logic [31:0] h, input logic [31:0] l);
        int          sa, sb;
        logic [31:0] r;
        logic        c;
        sa = av;
        sb = bv;
        r  = 32'd0;
        c  = 1'b0;
        case (f)
            5'd0:  r = av + bv;
            5'd1:  r = av - bv;
            5'd2:  r = av & bv;
            5'd3:  r = av | bv;
            5'd4:  r = av ^ bv;
            5'd5:  r = ~(av | bv);
            5'd6:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd7:  r = (av < bv) ? 32'd1 : 32'd0;
            5'd8:  r = bv << sh;
            5'd9:  r = bv >> sh;
            5'd10: r = sb >>> sh;
            5'd11: r = bv << (av % 32);
            5'd12: r = bv >> (av % 32);
            5'd13: r = sb >>> (av % 32);
            5'd14: r = bv * 32'h10000;
            5'd15: r = h;
            5'd16: r = l;
            5'd17: r = av;
            5'd18: begin r = av - bv; c = (sa == sb); end
            5'd19: begin r = av - bv; c = (sa != sb); end
            5'd20: begin r = av - bv; c = (sa <= 0);  end
            5'd21: begin r = av - bv; c = (sa > 0);   end
            5'd22: begin r = av - bv; c = (sa < 0);   end
            5'd23: begin r = av - bv; c = (sa >= 0);  end
            default: ;
        endcase
        return {c, r};
    endfunction

    task automatic model_hilo(input logic [2:0] mop, input logic [31:0] av, input logic [31:0] bv);
        longint          sp, q, rm;
        longint unsigned up;
        case (mop)
            3'd1: begin
                sp = longint'($signed(av)) * longint'($signed(bv));
                mh = sp[63:32]; ml = sp[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, av}) * longint'({32'd0, bv});
                mh = up[63:32]; ml = up[31:0];
            end
`ifdef MIPS_ALU_DIV_EN
            3'd3: if (bv != 0) begin
                q  = longint'($signed(av)) / longint'($signed(bv));
                rm = longint'($signed(av)) % longint'($signed(bv));
                ml = q[31:0]; mh = rm[31:0];
            end
            3'd4: if (bv != 0) begin
                q  = longint'({32'd0, av}) / longint'({32'd0, bv});
                rm = longint'({32'd0, av}) % longint'({32'd0, bv});
                ml = q[31:0]; mh = rm[31:0];
            end
`endif
            3'd5: mh = av;
            3'd6: ml = av;
            default: ;
        endcase
    endtask

    task automatic step(input logic [4:0] f, input logic [2:0] mop, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh, input logic wr);
        logic [32:0] e;
        @(negedge clk);
        alu_func = f; mult_op = mop; a = av; b = bv; shift = sh; write = wr;
        #1;
        e = model_alu(f, av, bv, sh, mh, ml);
        check("result", result, e[31:0]);
        check("condition", {31'd0, condition}, {31'd0, e[32]});
        @(posedge clk);
        if (wr) model_hilo(mop, av, bv);
        #1;
        write = 1'b0;
        check("hi", hi, mh);
        check("lo", lo, ml);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 9);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; alu_func = 5'd0; mult_op = 3'd0; a = 32'd0; b = 32'd0; shift = 5'd0; write = 1'b0;
        mh = 32'd0; ml = 32'd0;
        @(negedge clk); @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b0;

        step(5'd0, 3'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
        check("add_ovf", result, 32'h8000_0000);
        check("add_cond", {31'd0, condition}, 32'd0);
        step(5'd1, 3'd0, 32'd0, 32'd1, 5'd0, 1'b0);
        check("sub", result, 32'hFFFF_FFFF);
        step(5'd5, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("nor", result, 32'hFFFF_FFFF);
        step(5'd6, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        check("slt", result, 32'd1);
        step(5'd7, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        check("sltu", result, 32'd0);
        step(5'd10, 3'd0, 32'd0, 32'h8000_0000, 5'd4, 1'b0);
        check("sra", result, 32'hF800_0000);
        step(5'd12, 3'd0, 32'd36, 32'hF0, 5'd0, 1'b0);
        check("srlv", result, 32'h0000_000F);
        step(5'd14, 3'd0, 32'd0, 32'h1234, 5'd0, 1'b0);
        check("lui", result, 32'h1234_0000);
        step(5'd18, 3'd0, 32'd5, 32'd5, 5'd0, 1'b0);
        check("beq", {31'd0, condition}, 32'd1);
        step(5'd19, 3'd0, 32'd5, 32'd5, 5'd0, 1'b0);
        check("bne", {31'd0, condition}, 32'd0);
        step(5'd20, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("blez", {31'd0, condition}, 32'd1);
        step(5'd21, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        check("bgtz", {31'd0, condition}, 32'd0);
        step(5'd22, 3'd0, 32'h8000_0000, 32'd0, 5'd0, 1'b0);
        check("bltz", {31'd0, condition}, 32'd1);

        step(5'd5, 3'd5, 32'h1111_2222, 32'd0, 5'd0, 1'b1);
        step(5'd15, 3'd1, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        step(5'd15, 3'd2, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1);
        check("multu_hi", hi, 32'd2);
        check("multu_lo", lo, 32'hFFFF_FFFA);

        step(5'd0, 3'd3, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b1);
`ifdef MIPS_ALU_DIV_EN
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        step(5'd0, 3'd4, 32'd7, 32'd2, 5'd0, 1'b1);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);
        step(5'd0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b1);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        step(5'd0, 3'd3, 32'd9, 32'd0, 5'd0, 1'b1);
        check("div0_lo", lo, 32'h8000_0000);
        check("div0_hi", hi, 32'd0);
`else
        check("nodiv_hi", hi, 32'd2);
        check("nodiv_lo", lo, 32'hFFFF_FFFA);
`endif

        step(5'd0, 3'd5, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1);
        step(5'd0, 3'd6, 32'd1, 32'd0, 5'd0, 1'b1);
        check("mthi", hi, 32'hDEAD_BEEF);
        check("mtlo", lo, 32'd1);
        step(5'd0, 3'd7, 32'd5, 32'd5, 5'd0, 1'b1);
        step(5'd0, 3'd0, 32'd5, 32'd5, 5'd0, 1'b1);
        check("nop_hi", hi, 32'hDEAD_BEEF);

        for (int i = 0; i < 400; i++) begin
            step(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), pick(), pick(),
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        reset = 1'b1; write = 1'b1; mult_op = 3'd5; a = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mh = 32'd0; ml = 32'd0;
        check("rst_wr_hi", hi, mh);
        check("rst_wr_lo", lo, ml);
        reset = 1'b0; write = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_alu_core.md
# mips_cpu_alu_core

Combinational 32-bit integer ALU with registered HI/LO multiply/divide unit for the multi-cycle MIPS-I datapath. It takes a decoded function select from the ALU control decode and produces the datapath result and a branch condition flag. It also owns the architectural HI/LO registers, updated on a write strobe from the main controller. It sits between the A/B operand muxes and the ALUOut/PC/register-file write paths.

## Interface
- No parameters.
- clk  input  1  clock; HI/LO update on rising edge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- alu_func  input  5  ALU function select; encodings in Operation.
- mult_op  input  3  HI/LO operation select.
- a  input  32  operand A (register rs or PC).
- b  input  32  operand B (register rt or immediate).
- shift  input  5  shift amount (instruction shamt).
- write  input  1  HI/LO write strobe; applies mult_op on the next clock edge.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- condition  output  1  branch-taken flag.
- result  output  32  ALU result.

## Operation
- alu_func encodings for result; condition is 0 unless a branch code is stated:
  - 0 ADD: a+b, wrapping, no trap.
  - 1 SUB: a-b.
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed a<b gives 1, else 0.
  - 7 SLTU: unsigned a<b gives 1, else 0.
  - 8 SLL: b<<shift.
  - 9 SRL: b>>shift, logical.
  - 10 SRA: b>>>shift, arithmetic.
  - 11 SLLV, 12 SRLV, 13 SRAV: as 8-10, with amount a[4:0].
  - 14 LUI: {b[15:0],16'h0}.
  - 15 MFHI: result is hi.
  - 16 MFLO: result is lo.
  - 17 PASS_A: result is a.
- Branch codes, result = a-b in all cases:
  - 18 BEQ: condition = (a==b).
  - 19 BNE: condition = (a!=b).
  - 20 BLEZ: condition = signed a<=0.
  - 21 BGTZ: condition = signed a>0.
  - 22 BLTZ: condition = a[31].
  - 23 BGEZ: condition = !a[31].
- alu_func 24-31: result 0, condition 0.
- mult_op encodings, applied only when write=1:
  - 0 none.
  - 1 MULT: signed 64-bit product; {hi,lo} = a*b.
  - 2 MULTU: unsigned 64-bit product.
  - 3 DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - 4 DIVU: unsigned quotient and remainder.
  - 5 MTHI: hi = a, lo unchanged.
  - 6 MTLO: lo = a, hi unchanged.
  - 7 none.
- Divide by zero (b==0) for DIV or DIVU: hi and lo unchanged.
- Signed 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- write=1 with mult_op 0 or 7: no change.

## Timing
- result and condition are purely combinational from alu_func, a, b, shift and the current hi/lo.
- HI/LO latency is one edge: values become visible the cycle after write=1. MFHI/MFLO in the same cycle as a write return the old value.
- Reset: hi=0 and lo=0 at the first rising edge with reset=1. Reset overrides write.
- result and condition have no reset state; they track their inputs.
- Mult and div are single-cycle combinational. No busy or stall output is provided.

## Configuration
- MIPS_ALU_DIV_EN defined: DIV/DIVU implemented as specified.
- MIPS_ALU_DIV_EN undefined: mult_op 3 and 4 are no-ops and HI/LO stay unchanged. All other functions are identical.

## Test plan
- Arithmetic/logic: a=0x7FFFFFFF, b=1, ADD -> result 0x80000000, condition 0. SUB with a=0, b=1 -> 0xFFFFFFFF. NOR with a=b=0 -> 0xFFFFFFFF.
- Set/shift: SLT with a=0xFFFFFFFF, b=1 -> 1; SLTU with the same operands -> 0. SRA with b=0x80000000, shift=4 -> 0xF8000000. SRLV with a=36, b=0xF0 -> 0x0F. LUI with b=0x1234 -> 0x12340000.
- Branches: BEQ with a=b=5 -> condition 1. BNE with the same operands -> 0. BLEZ with a=0 -> 1. BGTZ with a=0 -> 0. BLTZ with a=0x80000000 -> 1. ADD -> condition 0.
- Multiply: MULT a=0xFFFFFFFE(-2), b=3, write=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA on the next cycle. MULTU with the same operands -> hi=2, lo=0xFFFFFFFA. MFHI in the write cycle returns the prior hi.
- Divide (MIPS_ALU_DIV_EN): DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1. DIV with b=0 -> hi/lo unchanged. Without the macro, DIV leaves hi/lo unchanged.
- Reset/MT: MTHI a=0xDEADBEEF, then MTLO a=1 -> hi=0xDEADBEEF, lo=1. Asserting reset and write in the same cycle -> hi=lo=0.
